// File: rtl/time_entry_encoder.sv
// time_entry_encoder: keypad-side encoder for the mm:ss timer.
// Collects up to four BCD digits (shifting in from the right), converts them
// on commit to {minutes[5:0], seconds[5:0]} and offers the result to the
// counter's load port over a valid/ready handshake.
// Optional build macro: TIME_ENTRY_AUTOCOMMIT_EN -- a legal 4th digit starts
// the conversion without an explicit commit.
module time_entry_encoder #(
    parameter int MAX_MIN = 63,
    parameter int MAX_SEC = 59
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [3:0]  digit_in,
    input  logic        digit_strobe,
    input  logic        commit,
    input  logic        clear,
    input  logic        time_ready,
    output logic [11:0] time_out,
    output logic        time_valid,
    output logic        error,
    output logic [2:0]  digit_count,
    output logic [15:0] bcd_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTRY   = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_VALID   = 2'd3;

    logic [1:0]  state;
    logic [15:0] bcd;
    logic [2:0]  count;
    logic [6:0]  min_val;
    logic [6:0]  sec_val;
    logic        range_bad;

    // Two BCD digits to binary: tens*10 + ones, at most 99 so 7 bits suffice.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] ones);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, ones};
    endfunction

    assign min_val   = bcd_to_bin(bcd[15:12], bcd[11:8]);
    assign sec_val   = bcd_to_bin(bcd[7:4], bcd[3:0]);
    assign range_bad = (min_val > 7'(MAX_MIN)) || (sec_val > 7'(MAX_SEC));

    assign digit_count = count;
    assign bcd_out     = bcd;

    // Entry / convert / handshake state machine; error is a one-cycle pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            bcd        <= 16'h0000;
            count      <= 3'd0;
            time_out   <= 12'h000;
            time_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            error <= 1'b0;
            if (clear) begin
                state      <= S_IDLE;
                bcd        <= 16'h0000;
                count      <= 3'd0;
                time_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_ENTRY: begin
                        if (commit) begin
                            // A commit always swallows a simultaneous digit;
                            // with nothing buffered it does nothing at all.
                            if (state == S_ENTRY) begin
                                state <= S_CONVERT;
                            end
                        end else if (digit_strobe) begin
                            if (digit_in > 4'd9) begin
                                error <= 1'b1;
                            end else if (count < 3'd4) begin
                                bcd   <= {bcd[11:0], digit_in};
                                count <= count + 3'd1;
`ifdef TIME_ENTRY_AUTOCOMMIT_EN
                                state <= (count == 3'd3) ? S_CONVERT : S_ENTRY;
`else
                                state <= S_ENTRY;
`endif
                            end
                        end
                    end
                    S_CONVERT: begin
                        if (range_bad) begin
                            error <= 1'b1;
                            bcd   <= 16'h0000;
                            count <= 3'd0;
                            state <= S_IDLE;
                        end else begin
                            time_out   <= {min_val[5:0], sec_val[5:0]};
                            time_valid <= 1'b1;
                            state      <= S_VALID;
                        end
                    end
                    S_VALID: begin
                        // time_out is left holding the delivered value.
                        if (time_ready) begin
                            time_valid <= 1'b0;
                            bcd        <= 16'h0000;
                            count      <= 3'd0;
                            state      <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_entry_encoder.sv
// Directed testbench for time_entry_encoder. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the capturing edge.
module tb_time_entry_encoder;

    logic        clk;
    logic        nrst;
    logic [3:0]  digit_in;
    logic        digit_strobe;
    logic        commit;
    logic        clear;
    logic        time_ready;
    logic [11:0] time_out;
    logic        time_valid;
    logic        error;
    logic [2:0]  digit_count;
    logic [15:0] bcd_out;

    int checks = 0;
    int errors = 0;

    time_entry_encoder dut (
        .clk          (clk),
        .nrst         (nrst),
        .digit_in     (digit_in),
        .digit_strobe (digit_strobe),
        .commit       (commit),
        .clear        (clear),
        .time_ready   (time_ready),
        .time_out     (time_out),
        .time_valid   (time_valid),
        .error        (error),
        .digit_count  (digit_count),
        .bcd_out      (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        @(negedge clk);
        digit_in     = d;
        digit_strobe = 1'b1;
        @(negedge clk);
        digit_strobe = 1'b0;
    endtask

    task automatic do_commit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic do_ready();
        @(negedge clk);
        time_ready = 1'b1;
        @(negedge clk);
        time_ready = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; digit_in = 4'd0; digit_strobe = 1'b0;
        commit = 1'b0; clear = 1'b0; time_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_time_out", 32'(time_out), 32'h0);
        check("rst_valid", 32'(time_valid), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_count", 32'(digit_count), 32'h0);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        nrst = 1'b1;
        @(negedge clk);

`ifdef TIME_ENTRY_AUTOCOMMIT_EN
        // 0,9,3,0 converts to 09:30 with no commit
        strobe(4'd0); strobe(4'd9); strobe(4'd3); strobe(4'd0);
        check("ac_bcd", 32'(bcd_out), 32'h0930);
        check("ac_valid_early", 32'(time_valid), 32'h0);
        @(negedge clk);
        check("ac_valid", 32'(time_valid), 32'h1);
        check("ac_time", 32'(time_out), 32'h25E);
        do_ready();
        check("ac_release", 32'(time_valid), 32'h0);
        check("ac_count", 32'(digit_count), 32'h0);
`else
        // 12:34 with a 2-cycle commit latency
        strobe(4'd1); strobe(4'd2); strobe(4'd3); strobe(4'd4);
        check("t1_bcd", 32'(bcd_out), 32'h1234);
        check("t1_count", 32'(digit_count), 32'h4);
        do_commit();
        check("t1_valid_convert", 32'(time_valid), 32'h0);
        @(negedge clk);
        check("t1_valid", 32'(time_valid), 32'h1);
        check("t1_time", 32'(time_out), 32'h322);

        // held in VALID while ready low; strobes/commit ignored
        strobe(4'd5);
        do_commit();
        repeat (2) @(negedge clk);
        check("hold_valid", 32'(time_valid), 32'h1);
        check("hold_time", 32'(time_out), 32'h322);
        check("hold_bcd", 32'(bcd_out), 32'h1234);
        check("hold_count", 32'(digit_count), 32'h4);
        do_ready();
        check("rel_valid", 32'(time_valid), 32'h0);
        check("rel_count", 32'(digit_count), 32'h0);
        check("rel_bcd", 32'(bcd_out), 32'h0);
        check("rel_time_held", 32'(time_out), 32'h322);

        // 00:45
        strobe(4'd4); strobe(4'd5);
        check("t2_bcd", 32'(bcd_out), 32'h0045);
        do_commit();
        @(negedge clk);
        check("t2_valid", 32'(time_valid), 32'h1);
        check("t2_time", 32'(time_out), 32'h02D);
        do_ready();

        // seconds out of range: 01:75
        strobe(4'd0); strobe(4'd1); strobe(4'd7); strobe(4'd5);
        do_commit();
        @(negedge clk);
        check("sec_bad_error", 32'(error), 32'h1);
        check("sec_bad_valid", 32'(time_valid), 32'h0);
        check("sec_bad_count", 32'(digit_count), 32'h0);
        @(negedge clk);
        check("sec_bad_pulse", 32'(error), 32'h0);
        check("sec_bad_valid2", 32'(time_valid), 32'h0);

        // minutes out of range: 70:00
        strobe(4'd7); strobe(4'd0); strobe(4'd0); strobe(4'd0);
        do_commit();
        @(negedge clk);
        check("min_bad_error", 32'(error), 32'h1);
        check("min_bad_valid", 32'(time_valid), 32'h0);
        check("min_bad_bcd", 32'(bcd_out), 32'h0);
        @(negedge clk);
        check("min_bad_pulse", 32'(error), 32'h0);

        // illegal digit
        strobe(4'hA);
        check("bad_digit_error", 32'(error), 32'h1);
        check("bad_digit_count", 32'(digit_count), 32'h0);

        // 5th legal digit ignored silently
        strobe(4'd1); strobe(4'd2); strobe(4'd3); strobe(4'd4);
        strobe(4'd5);
        check("fifth_bcd", 32'(bcd_out), 32'h1234);
        check("fifth_count", 32'(digit_count), 32'h4);
        check("fifth_error", 32'(error), 32'h0);

        // clear beats commit
        @(negedge clk);
        clear = 1'b1; commit = 1'b1;
        @(negedge clk);
        clear = 1'b0; commit = 1'b0;
        check("clr_count", 32'(digit_count), 32'h0);
        check("clr_bcd", 32'(bcd_out), 32'h0);
        check("clr_error", 32'(error), 32'h0);
        repeat (2) @(negedge clk);
        check("clr_valid", 32'(time_valid), 32'h0);

        // async reset while VALID (00:12)
        strobe(4'd1); strobe(4'd2);
        do_commit();
        @(negedge clk);
        check("pre_rst_valid", 32'(time_valid), 32'h1);
        check("pre_rst_time", 32'(time_out), 32'h00C);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_valid", 32'(time_valid), 32'h0);
        check("arst_time", 32'(time_out), 32'h0);
        check("arst_bcd", 32'(bcd_out), 32'h0);
        check("arst_count", 32'(digit_count), 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(time_valid), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
